// File: rtl/vga_timing_gen.sv
// 640x480 VGA raster timing: free-running pixel/line counters plus hs/vs/blank
// delayed through a short register pipeline to line up with mapper RGB output.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       sync,
  output logic       frame_start,
  output logic       line_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  // A zero-depth request still gets one register so the pins stay glitch-free.
  localparam int unsigned DEPTH   = (SYNC_DELAY == 0) ? 1 : SYNC_DELAY;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACTIVE = 10'(H_VISIBLE);
  localparam logic [9:0] V_ACTIVE = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  if (H_TOTAL > 1023 || V_TOTAL > 1023 || SYNC_DELAY > 7) begin : g_param_check
    $error("vga_timing_gen: line/frame totals must fit 10-bit counters and SYNC_DELAY must be 0..7");
  end

  logic [9:0] hc_reg;
  logic [9:0] vc_reg;
  logic       hs_raw;
  logic       vs_raw;
  logic       blank_raw;
  logic [DEPTH-1:0] hs_pipe;
  logic [DEPTH-1:0] vs_pipe;
  logic [DEPTH-1:0] blank_pipe;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hc_reg <= '0;
      vc_reg <= '0;
    end else if (hc_reg == H_LAST) begin
      hc_reg <= '0;
      vc_reg <= (vc_reg == V_LAST) ? 10'd0 : vc_reg + 10'd1;
    end else begin
      hc_reg <= hc_reg + 10'd1;
    end
  end

  always_comb begin
    hs_raw    = !((hc_reg >= HS_START) && (hc_reg < HS_END));
    vs_raw    = !((vc_reg >= VS_START) && (vc_reg < VS_END));
    blank_raw = (hc_reg < H_ACTIVE) && (vc_reg < V_ACTIVE);
  end

  // Stage 0 samples the raw timing; the last stage drives the pins.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hs_pipe    <= '1;
      vs_pipe    <= '1;
      blank_pipe <= '0;
    end else begin
      hs_pipe[0]    <= hs_raw;
      vs_pipe[0]    <= vs_raw;
      blank_pipe[0] <= blank_raw;
      for (int i = 1; i < int'(DEPTH); i++) begin
        hs_pipe[i]    <= hs_pipe[i-1];
        vs_pipe[i]    <= vs_pipe[i-1];
        blank_pipe[i] <= blank_pipe[i-1];
      end
    end
  end

  assign DrawX       = hc_reg;
  assign DrawY       = vc_reg;
  assign hs          = hs_pipe[DEPTH-1];
  assign vs          = vs_pipe[DEPTH-1];
  assign blank       = blank_pipe[DEPTH-1];
  assign sync        = 1'b0;
  assign frame_start = (hc_reg == 10'd0) && (vc_reg == 10'd0) && !reset;
  assign line_start  = (hc_reg == 10'd0) && !reset;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default build, SYNC_DELAY=0 build, and a shrunken-geometry
// build so a full frame fits in a short run.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic [9:0] ax, ay, zx, zy, sx, sy;
  logic a_hs, a_vs, a_blank, a_sync, a_fs, a_ls;
  logic z_hs, z_vs, z_blank, z_sync, z_fs, z_ls;
  logic s_hs, s_vs, s_blank, s_sync, s_fs, s_ls;

  vga_timing_gen dut_a (
    .vga_clk(clk), .reset(rst), .DrawX(ax), .DrawY(ay), .hs(a_hs), .vs(a_vs),
    .blank(a_blank), .sync(a_sync), .frame_start(a_fs), .line_start(a_ls)
  );

  vga_timing_gen #(.SYNC_DELAY(0)) dut_z (
    .vga_clk(clk), .reset(rst), .DrawX(zx), .DrawY(zy), .hs(z_hs), .vs(z_vs),
    .blank(z_blank), .sync(z_sync), .frame_start(z_fs), .line_start(z_ls)
  );

  // 15 clocks/line (hs low hc 10..12), 8 lines/frame (vs low vc 5..6), 120 clocks/frame.
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_DELAY(2)
  ) dut_s (
    .vga_clk(clk), .reset(rst), .DrawX(sx), .DrawY(sy), .hs(s_hs), .vs(s_vs),
    .blank(s_blank), .sync(s_sync), .frame_start(s_fs), .line_start(s_ls)
  );

  int total = 0;
  int passed = 0;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  initial begin
    int hs_fall_a = -1, hs_rise_a = -1, hs_low_a = 0;
    int blank_rise_a = -1, blank_fall_a = -1, ls_cnt_a = 0, fs_cnt_a = 0;
    int hs_fall_z = -1, blank_rise_z = -1, z_bad = 0;
    int vs_fall_s = -1, vs_low_s = 0, blank_hi_s = 0, fs_cnt_s = 0, hs_fall_s = -1;

    // Reset held for 5 cycles
    repeat (5) @(negedge clk);
    check("rst_hs", a_hs, 1);
    check("rst_vs", a_vs, 1);
    check("rst_blank", a_blank, 0);
    check("rst_drawx", ax, 0);
    check("rst_drawy", ay, 0);
    check("rst_frame_start", a_fs, 0);
    check("rst_line_start", a_ls, 0);
    check("sync_tied", a_sync, 0);

    rst = 1'b0;
    #1;
    check("rel_frame_start", a_fs, 1);
    check("rel_line_start", a_ls, 1);
    check("rel_drawx", ax, 0);
    check("rel_blank_hold", a_blank, 0);

    // Two default lines; k counts rising edges since release.
    for (int k = 0; k < 1600; k++) begin
      if (k > 0) @(negedge clk);
      if (hs_fall_a < 0 && a_hs == 1'b0) hs_fall_a = k;
      if (hs_fall_a >= 0 && hs_rise_a < 0 && a_hs == 1'b1) hs_rise_a = k;
      if (k < 800 && a_hs == 1'b0) hs_low_a++;
      if (blank_rise_a < 0 && a_blank == 1'b1) blank_rise_a = k;
      if (blank_rise_a >= 0 && blank_fall_a < 0 && a_blank == 1'b0) blank_fall_a = k;
      if (a_ls) ls_cnt_a++;
      if (a_fs) fs_cnt_a++;
      if (hs_fall_z < 0 && z_hs == 1'b0) hs_fall_z = k;
      if (blank_rise_z < 0 && z_blank == 1'b1) blank_rise_z = k;
      if (int'(zx) != k % 800 || int'(zy) != k / 800) z_bad++;
      if (hs_fall_s < 0 && s_hs == 1'b0) hs_fall_s = k;
      if (vs_fall_s < 0 && s_vs == 1'b0) vs_fall_s = k;
      if (k < 120 && s_vs == 1'b0) vs_low_s++;
      if (k < 122 && s_blank == 1'b1) blank_hi_s++;
      if (k < 240 && s_fs) fs_cnt_s++;
      if (k == 798) begin
        check("wrap_x798", ax, 798);
        check("wrap_y798", ay, 0);
      end
      if (k == 799) check("wrap_x799", ax, 799);
      if (k == 800) begin
        check("wrap_x800", ax, 0);
        check("wrap_y800", ay, 1);
        check("wrap_line_start", a_ls, 1);
      end
      if (k == 119) begin
        check("s_last_x", sx, 14);
        check("s_last_y", sy, 7);
      end
      if (k == 120) begin
        check("s_wrap_x", sx, 0);
        check("s_wrap_y", sy, 0);
        check("s_wrap_fs", s_fs, 1);
      end
    end

    check("a_hs_fall_cycle", hs_fall_a, 658);
    check("a_hs_rise_cycle", hs_rise_a, 754);
    check("a_hs_low_len", hs_low_a, 96);
    check("a_blank_rise_cycle", blank_rise_a, 2);
    check("a_blank_fall_cycle", blank_fall_a, 642);
    check("a_line_start_cnt", ls_cnt_a, 2);
    check("a_frame_start_cnt", fs_cnt_a, 1);
    check("z_hs_fall_cycle", hs_fall_z, 657);
    check("z_blank_rise_cycle", blank_rise_z, 1);
    check("z_counter_seq_bad", z_bad, 0);
    check("s_hs_fall_cycle", hs_fall_s, 12);
    check("s_vs_fall_cycle", vs_fall_s, 77);
    check("s_vs_low_len", vs_low_s, 30);
    check("s_blank_hi_len", blank_hi_s, 32);
    check("s_frame_start_cnt", fs_cnt_s, 2);

    // Move to DrawX=300, DrawY=2 (visible) and reset mid-line between edges.
    repeat (301) @(negedge clk);
    check("mid_pre_x", ax, 300);
    check("mid_pre_y", ay, 2);
    check("mid_pre_blank", a_blank, 1);
    rst = 1'b1;
    #1;
    check("mid_async_x", ax, 0);
    check("mid_async_y", ay, 0);
    check("mid_async_blank", a_blank, 0);
    check("mid_async_hs", a_hs, 1);
    check("mid_async_vs", a_vs, 1);
    check("mid_async_ls", a_ls, 0);
    check("mid_async_fs", a_fs, 0);
    repeat (3) @(negedge clk);
    check("mid_hold_x", ax, 0);
    check("mid_hold_blank", a_blank, 0);
    rst = 1'b0;
    #1;
    check("mid_rel_fs", a_fs, 1);
    check("mid_rel_y", ay, 0);
    @(negedge clk);
    check("mid_k1_x", ax, 1);
    check("mid_k1_blank", a_blank, 0);
    @(negedge clk);
    check("mid_k2_blank", a_blank, 1);
    check("mid_k2_hs", a_hs, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Pixel-timing generator for the 640x480 background/sprite pipeline.
- Drives the DrawX/DrawY raster coordinates consumed by every *_mapper stage.
- Drives hs/vs/blank to the VGA pins, delayed by a fixed pipeline depth so they line up with mapper RGB output. Mappers have 1 cycle ROM read plus 1 cycle output register, so the default depth is 2.
- Runs on the 25 MHz pixel clock.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_DELAY, 2, pipeline stages applied to hs/vs/blank (legal range 0..7)

Ports:
- vga_clk  input  1  pixel clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-high reset
- DrawX  output  10  current pixel column, equal to the horizontal counter hc
- DrawY  output  10  current line, equal to the vertical counter vc
- hs  output  1  horizontal sync, active low, delayed SYNC_DELAY cycles
- vs  output  1  vertical sync, active low, delayed SYNC_DELAY cycles
- blank  output  1  display enable, high = visible pixel, delayed SYNC_DELAY cycles
- sync  output  1  composite sync, tied to 0
- frame_start  output  1  one-cycle pulse when hc=0 and vc=0; not delayed
- line_start  output  1  one-cycle pulse when hc=0; not delayed

Behaviour:
- Derived constants: H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525).
- Reset (asynchronous, takes effect immediately, mid-frame included):
  - hc=0, vc=0, so DrawX=0 and DrawY=0.
  - Every delay-pipeline stage is loaded with inactive values: hs=1, vs=1, blank=0.
  - frame_start and line_start are forced to 0 while reset is high.
- Horizontal counter:
  - hc increments every cycle.
  - At hc = H_TOTAL-1 it wraps to 0 on the next edge.
- Vertical counter:
  - vc increments only on the edge where hc wraps.
  - When hc = H_TOTAL-1 and vc = V_TOTAL-1, both wrap to 0 on the same edge.
- Raw (undelayed) timing, evaluated combinationally from the counter registers:
  - hs_raw = 0 iff H_VISIBLE+H_FRONT ≤ hc < H_VISIBLE+H_FRONT+H_SYNC, i.e. hc in [656,751].
  - vs_raw = 0 iff V_VISIBLE+V_FRONT ≤ vc < V_VISIBLE+V_FRONT+V_SYNC, i.e. vc in [490,491].
  - blank_raw = 1 iff hc < H_VISIBLE and vc < V_VISIBLE.
- Delay pipeline:
  - hs/vs/blank are hs_raw/vs_raw/blank_raw passed through SYNC_DELAY register stages clocked by vga_clk.
  - If SYNC_DELAY=0 they are registered once, giving 1-cycle latency; this is a documented exception.
  - DrawX/DrawY are never delayed.
- Pulses:
  - frame_start = (hc==0 && vc==0) && !reset.
  - line_start = (hc==0) && !reset.
  - Both last exactly one cycle per frame / line.
- Counter widths are 10 bits. Parameter sums above 1023 are unsupported; flag with an elaboration-time assertion.
- No handshakes; the block is free-running once reset deasserts.
- First cycle after reset release: DrawX=0, DrawY=0, frame_start=1, line_start=1.
- With SYNC_DELAY=2 and reset released with counters at 0:
  - blank first goes to 1 at the 2nd edge after reset release.
  - Before that it holds the reset value 0.

Test Plan:
- Reset asserted for 5 cycles, then released -> during reset hs=1, vs=1, blank=0, DrawX=0, DrawY=0, frame_start=0; first cycle after release frame_start=1, line_start=1.
- Run one line with SYNC_DELAY=2 -> hs falls 2 cycles after DrawX=656 and rises 2 cycles after DrawX=752; hs low for exactly 96 cycles; blank falls 2 cycles after DrawX=640.
- Line wrap -> DrawX sequence 798, 799, 0 with DrawY incrementing 0→1 on the same edge; line_start pulses once per 800 cycles.
- Full frame (420000 cycles) -> vs low for exactly 1600 cycles, starting 2 cycles after DrawY=490/DrawX=0; DrawY wraps 524→0 with frame_start pulsing once; blank high for exactly 307200 cycles.
- Reset asserted at DrawX=300, DrawY=200 -> all outputs take reset values asynchronously in the same cycle, without waiting for a clock edge; the pipeline refills with inactive values; after release the counters restart at 0,0.
- SYNC_DELAY=0 build -> hs falls 1 cycle after DrawX=656; the counter sequence is identical to the default build.
